// File: rtl/ram_reader_pkg.sv
// Shared types and defaults for the RAM read-out path.
//   state_t   : sweep FSM states
//   AW_DEF    : default RAM address width
//   DW_DEF    : default RAM data width
//   RAM_WORDS : RAM word count for the default address width
package ram_reader_pkg;

    localparam int unsigned AW_DEF    = 5;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned RAM_WORDS = 2 ** AW_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/ram_reader_fifo.sv
// Small synchronous FIFO with occupancy count; head word is visible on rdata.
//   clk, rst_n : clock, asynchronous active-low reset (flushes contents)
//   push/wdata : write side; accepted when not full, or when full with a pop
//   pop/rdata  : read side; rdata is the head entry, pop ignored when empty
//   full/empty : status flags
//   count      : number of stored entries, 0..DEPTH
module ram_reader_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 13
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointer advance that also works for non power-of-two depths.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ram_reader.sv
// Sweeps an address range of a synchronous RAM and streams each word out
// over valid/ready together with the address it came from.
//   CLOCK_50, RESET_N       : clock, asynchronous active-low reset
//   start, first_addr,
//   last_addr               : launch a sweep over first..last (wrapping)
//   ram_addr, ram_rden,
//   ram_q                   : RAM read port (data RD_LAT cycles after rden edge)
//   out_data, out_addr,
//   out_valid, out_ready    : output stream
//   busy, done              : sweep in progress / one-cycle end-of-sweep pulse
// Optional: RAM_READER_LOOP_EN adds input `loop` for continuous re-sweeping.
module ram_reader
    import ram_reader_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
`ifdef RAM_READER_LOOP_EN
    input  logic          loop,
`endif
    output logic [AW-1:0] ram_addr,
    output logic          ram_rden,
    input  logic [DW-1:0] ram_q,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = DW + AW;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_nxt;
    logic [LW-1:0]   remaining;
    logic [LW-1:0]   remaining_nxt;
    logic            busy_nxt;
    logic            done_nxt;
    logic [AW-1:0]   diff;
    logic [LW-1:0]   span;
    logic            issue;
    logic            credit;
    logic            push;
    logic            pop;
    logic [RD_LAT-1:0] dly_valid;
    logic [AW-1:0]   dly_addr [RD_LAT];
    logic [EW-1:0]   head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
`ifdef RAM_READER_LOOP_EN
    logic [AW-1:0]   first_q;
    logic [LW-1:0]   len_q;
`endif

    // Word count of the requested range, 1..2**AW.
    assign diff = last_addr - first_addr;
    assign span = {1'b0, diff} + LW'(1);

    assign pop  = !fifo_empty && out_ready;
    assign push = dly_valid[RD_LAT-1];

    // Reserve a FIFO slot for every read in flight; a pop this cycle frees one,
    // which is what sustains one word per cycle with FIFO_DEPTH = RD_LAT + 1.
    assign credit = (SW'(fifo_count) + SW'($countones(dly_valid)))
                  < (SW'(FIFO_DEPTH) + SW'(pop));

    // Next-state and register updates for the sweep FSM.
    always_comb begin
        state_nxt     = state;
        rd_ptr_nxt    = rd_ptr;
        remaining_nxt = remaining;
        issue         = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    rd_ptr_nxt    = first_addr;
                    remaining_nxt = span;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue         = 1'b1;
                    rd_ptr_nxt    = rd_ptr + AW'(1);
                    remaining_nxt = remaining - LW'(1);
                    if (remaining == LW'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((dly_valid == '0) &&
                    (fifo_empty || ((fifo_count == CW'(1)) && pop))) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
`ifdef RAM_READER_LOOP_EN
                if (loop) begin
                    rd_ptr_nxt    = first_q;
                    remaining_nxt = len_q;
                    state_nxt     = ISSUE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        done_nxt = (state_nxt == FIN);
        busy_nxt = (state_nxt == ISSUE) || (state_nxt == DRAIN);
`ifdef RAM_READER_LOOP_EN
        if ((state_nxt == FIN) && loop) busy_nxt = 1'b1;
`endif
    end

    // FSM state and sweep bookkeeping registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_ptr    <= rd_ptr_nxt;
            remaining <= remaining_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

`ifdef RAM_READER_LOOP_EN
    // Range kept for continuous re-sweeps.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            first_q <= '0;
            len_q   <= '0;
        end else if ((state == IDLE) && start) begin
            first_q <= first_addr;
            len_q   <= span;
        end
    end
`endif

    // Address/valid delay line matching the RAM read latency; reset drops
    // any read still in flight so late ram_q is never captured.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            dly_valid <= '0;
            for (int k = 0; k < RD_LAT; k++) dly_addr[k] <= '0;
        end else begin
            dly_valid[0] <= issue;
            dly_addr[0]  <= rd_ptr;
            for (int k = 1; k < RD_LAT; k++) begin
                dly_valid[k] <= dly_valid[k-1];
                dly_addr[k]  <= dly_addr[k-1];
            end
        end
    end

    ram_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .push  (push),
        .wdata ({ram_q, dly_addr[RD_LAT-1]}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The read strobe depends on this cycle's pop, so it is decoded directly.
    assign ram_rden  = issue;
    assign ram_addr  = rd_ptr;
    assign out_valid = !fifo_empty;
    assign out_data  = head[EW-1:AW];
    assign out_addr  = head[AW-1:0];

    // A returning word must always find room in the FIFO.
    assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
                     !(push && fifo_full && !pop));

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: full, wrapped and single-word sweeps,
// random back-pressure, mid-sweep reset, start-while-busy and (when
// RAM_READER_LOOP_EN is defined) continuous mode.
module tb_ram_reader;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] first_addr;
    logic [4:0] last_addr;
    logic [4:0] ram_addr;
    logic       ram_rden;
    logic [7:0] ram_q;
    logic [7:0] out_data;
    logic [4:0] out_addr;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
`ifdef RAM_READER_LOOP_EN
    logic       loop;
`endif

    logic [7:0] ram_mem [32];

    int  n_checks;
    int  n_fail;
    int  cycle;
    int  start_cycle;
    int  done_cycle;
    int  done_cnt;
    int  outstanding;
    int  got_addr[$];
    int  got_data[$];
    int  got_cyc[$];
    bit  rnd_ready;
    int  stall_run;
    bit  prev_stall;
    logic [12:0] prev_word;

    ram_reader dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
`ifdef RAM_READER_LOOP_EN
        .loop       (loop),
`endif
        .ram_addr   (ram_addr),
        .ram_rden   (ram_rden),
        .ram_q      (ram_q),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32x8 RAM, registered address, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_rden) ram_q <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Consumer: always ready, or random with stalls capped at 5 cycles.
    always @(posedge clk) begin
        #1;
        if (rnd_ready) begin
            if (stall_run >= 5 || $urandom_range(0, 1) == 1) begin
                out_ready = 1'b1;
                stall_run = 0;
            end else begin
                out_ready = 1'b0;
                stall_run++;
            end
        end else begin
            out_ready = 1'b1;
            stall_run = 0;
        end
    end

    // Stream monitor: collects words, checks stall stability and read credit.
    always @(negedge clk) begin : mon
        bit hs;
        bit ok;
        cycle++;
        if (!rst_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            hs = out_valid && out_ready;
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_word", 32'({out_addr, out_data}), 32'(prev_word));
            end
            if (ram_rden) begin
                ok = (outstanding - int'(hs)) < DEPTH;
                check("credit", 32'(ok), 32'd1);
            end
            outstanding = outstanding + int'(ram_rden) - int'(hs);
            if (hs) begin
                got_addr.push_back(32'(out_addr));
                got_data.push_back(32'(out_data));
                got_cyc.push_back(cycle);
            end
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
            end
            if (start) start_cycle = cycle;
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_addr, out_data};
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
        check({tag, "_ram_rden"},  32'(ram_rden),  32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_addr"},  32'(out_addr),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    task automatic clear_words();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    task automatic pulse_start(input int f, input int l);
        @(posedge clk); #1;
        first_addr = 5'(f);
        last_addr  = 5'(l);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    // Expected stream: addresses first..last modulo 32, data = addr*3.
    task automatic check_words(input int f, input int l, input string tag);
        int n;
        int a;
        n = ((l - f + 32) % 32) + 1;
        check({tag, "_count"}, 32'(got_addr.size()), 32'(n));
        for (int k = 0; k < n && k < got_addr.size(); k++) begin
            a = (f + k) % 32;
            check({tag, "_addr"}, 32'(got_addr[k]), 32'(a));
            check({tag, "_data"}, 32'(got_data[k]), 32'((a * 3) % 256));
        end
    endtask

    task automatic run_sweep(input int f, input int l, input int budget, input string tag);
        clear_words();
        pulse_start(f, l);
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(budget, tag);
        repeat (3) @(negedge clk);
        check_words(f, l, tag);
    endtask

    initial begin : stim
        int d0;
        int drops;
        int k;
        rst_n      = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        ram_q      = '0;
        out_ready  = 1'b1;
        rnd_ready  = 1'b0;
`ifdef RAM_READER_LOOP_EN
        loop       = 1'b0;
`endif
        for (int i = 0; i < 32; i++) ram_mem[i] = 8'(i * 3);

        repeat (3) @(negedge clk);
        check_reset("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("post_reset");

        // Full sweep at full rate: back-to-back words, done one cycle later.
        run_sweep(0, 31, 200, "full");
        if (got_cyc.size() == 32) begin
            check("full_back_to_back", 32'(got_cyc[31] - got_cyc[0]), 32'd31);
            check("full_done_gap", 32'(done_cycle - got_cyc[31]), 32'd1);
            check("full_latency", 32'(done_cycle - start_cycle), 32'd35);
        end

        run_sweep(28, 3, 100, "wrap");
        run_sweep(17, 17, 50, "single");

        rnd_ready = 1'b1;
        run_sweep(0, 31, 2000, "rand");
        rnd_ready = 1'b0;

        // Reset after the 10th word of a full sweep.
        clear_words();
        d0 = done_cnt;
        pulse_start(0, 31);
        for (int i = 0; i < 200 && got_addr.size() < 10; i++) @(negedge clk);
        check("rst_reached_10", 32'(got_addr.size() >= 10), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_idle_valid", 32'(out_valid), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'd0);
        run_sweep(5, 9, 100, "after_rst");

        // A second start while busy is ignored.
        clear_words();
        d0 = done_cnt;
        pulse_start(0, 7);
        repeat (2) @(negedge clk);
        pulse_start(20, 25);
        wait_done(100, "busy_start");
        repeat (20) @(negedge clk);
        check("busy_start_done_count", 32'(done_cnt - d0), 32'd1);
        check_words(0, 7, "busy_start");

`ifdef RAM_READER_LOOP_EN
        // Continuous mode over 0..3: one done per 4 words, busy never drops.
        clear_words();
        d0    = done_cnt;
        drops = 0;
        loop  = 1'b1;
        pulse_start(0, 3);
        for (int i = 0; i < 300 && (done_cnt - d0) < 3; i++) begin
            @(negedge clk); #1;
            if (!busy) drops++;
        end
        loop = 1'b0;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("loop_busy_drops", 32'(drops), 32'd0);
        check("loop_done_count", 32'(done_cnt - d0), 32'd3);
        check("loop_word_count", 32'(got_addr.size()), 32'd12);
        for (int i = 0; i < got_addr.size(); i++) begin
            k = i % 4;
            check("loop_addr", 32'(got_addr[i]), 32'(k));
            check("loop_data", 32'(got_data[i]), 32'(k * 3));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
